vga_stream_ctrl: RTL and testbench
==================================

Name: vga_stream_ctrl

Overview:
Pixel-clock-domain scheduler between the framebuffer pixel FIFO (read side) and the VGA timing generator.
- Decides when the display starts consuming pixels: after the FIFO is primed and at a frame boundary.
- Issues one FIFO read per visible pixel and drives registered RGB aligned with delayed sync/DE.
- Detects underflow and geometry errors, drains and resynchronises the stream at the next frame boundary.

Parameters:
HDISP, 800, visible pixels per line
VDISP, 480, visible lines per frame
LEVEL_W, 10, width of FIFO fill-level input
FILL_THRESH, 256, minimum FIFO level before streaming may start
UNDERFLOW_COLOR, 24'hFF00FF, pixel value output on underflow cycle

Ports:
pixel_clk  in  1  pixel clock
pixel_rst  in  1  asynchronous reset, active-high
enable  in  1  streaming enable (level)
vga_hs  in  1  HS from timing generator, active-low
vga_vs  in  1  VS from timing generator, active-low
vga_de  in  1  display enable, high on visible pixels
fifo_rdata  in  24  show-ahead FIFO head, {R,G,B} 8:8:8
fifo_rempty  in  1  FIFO empty
fifo_level  in  LEVEL_W  FIFO fill level
fifo_rd  out  1  FIFO read strobe (combinational)
rgb  out  24  registered pixel
hs_o / vs_o / de_o  out  1 each  vga_hs/vs/de delayed one cycle
resync_req  out  1  one-cycle pulse: writer must restart at frame start
underflow  out  1  sticky underflow flag
geom_err  out  1  sticky: streamed frame pixel count != HDISP*VDISP
err_cnt  out  8  saturating count of underflow events
busy  out  1  state == STREAM

Behaviour:
- Reset values (all registers, async): state IDLE, rgb 0, hs_o 1, vs_o 1, de_o 0, resync_req 0, underflow 0, geom_err 0, err_cnt 0, pixel counter 0, vs_q 1.
- Frame events: vs_q is vga_vs registered.
  - sync_start = vs_q & ~vga_vs (VS falling).
  - sof = ~vs_q & vga_vs (VS rising).
- States and transitions:
  - IDLE: enable=1 -> WAIT_FILL.
  - WAIT_FILL: enable=0 -> IDLE. fifo_level >= FILL_THRESH -> WAIT_SOF.
  - WAIT_SOF: enable=0 -> IDLE. sof -> STREAM, pixel counter cleared.
  - STREAM: fifo_rd = vga_de & ~fifo_rempty. Each read increments the pixel counter (width clog2(HDISP*VDISP+1)).
    - vga_de & fifo_rempty = underflow: no read, rgb <= UNDERFLOW_COLOR, underflow <= 1, err_cnt +1 (saturates at 255), -> RESYNC.
    - sync_start: if counter != HDISP*VDISP, geom_err <= 1. Then -> IDLE if enable=0, else stay in STREAM with counter cleared (continuous streaming).
  - RESYNC: fifo_rd = ~fifo_rempty (drain); rgb <= 0. On sync_start: resync_req pulses 1 cycle -> WAIT_FILL (IDLE if enable=0).
- enable deassertion in STREAM takes effect only at the next sync_start; the frame always completes.
- Datapath, one-cycle latency:
  - rgb <= fifo_rdata when fifo_rd in STREAM; 0 when vga_de=0 or state != STREAM (except the underflow cycle).
  - hs_o/vs_o/de_o <= vga_hs/vga_vs/vga_de every cycle.
- Simultaneous events:
  - Underflow on the last pixel of a frame still enters RESYNC; resync happens at the following sync_start.
  - sync_start and de never coincide: sync lies in blanking.
- fifo_rd is never asserted while fifo_rempty=1, in any state.
- Sticky flags clear only on reset.
- Reset mid-frame: immediate return to IDLE, outputs at reset values. Restart waits for fill plus the next sof, so no partial frame is shown.

Decomposition:
- vga_pkg holds:
  - stream_state_t enum {IDLE, WAIT_FILL, WAIT_SOF, STREAM, RESYNC}
  - rgb_t (24-bit packed struct r,g,b)
  - default HDISP/VDISP constants shared with the timing generator
- One natural sub-module: vga_frame_evt (vs register plus sync_start/sof decode), reusable by other pixel-domain blocks.
- Everything else inline.

Test Plan:
- Reset then enable=1, fifo_level=255 -> stays WAIT_FILL, fifo_rd=0. Level 256 -> WAIT_SOF. Next VS rising -> STREAM.
- Full 800x480 frame with FIFO never empty -> exactly 384000 fifo_rd pulses. rgb equals fifo_rdata one cycle after de. geom_err=0.
- FIFO empty at pixel 1000 of a frame -> rgb=FF00FF that cycle, underflow=1, err_cnt=1. Drain until empty. resync_req pulses once at next VS falling. State WAIT_FILL.
- Test timing generator with VDISP=479 (one line short) -> geom_err=1 at next VS falling. Streaming continues.
- enable dropped mid-frame -> reads continue to end of frame. IDLE at VS falling. No further fifo_rd.
- pixel_rst asserted mid-line -> all outputs at reset values within the same cycle; 256 underflows -> err_cnt holds 255.

Source files
------------

// File: rtl/vga_pkg.sv
// Shared pixel-domain types and constants for the VGA streaming path.
// The timing generator uses the same default geometry, so both blocks
// always agree on the frame size.
package vga_pkg;

    // Default visible geometry, shared with the timing generator
    localparam int HDISP_DEF = 800;
    localparam int VDISP_DEF = 480;

    // Scheduler states
    typedef enum logic [2:0] {
        IDLE,
        WAIT_FILL,
        WAIT_SOF,
        STREAM,
        RESYNC
    } stream_state_t;

    // One pixel, 8:8:8, red in the top byte
    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb_t;

    // Increment that sticks at all-ones, for 8-bit event counters
    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/vga_frame_evt.sv
// Frame event decoder: registers the active-low VS and flags its two edges.
// sync_start marks VS falling (end of a frame, inside blanking).
// sof marks VS rising (the next visible frame is about to begin).
module vga_frame_evt (
    input  logic pixel_clk,
    input  logic pixel_rst,
    input  logic i_vs,
    output logic o_sync_start,
    output logic o_sof
);

    logic r_vs_q;

    // Previous VS level; idles high because VS is active-low
    always_ff @(posedge pixel_clk or posedge pixel_rst) begin
        if (pixel_rst) begin
            r_vs_q <= 1'b1;
        end else begin
            r_vs_q <= i_vs;
        end
    end

    assign o_sync_start = r_vs_q & ~i_vs;
    assign o_sof        = ~r_vs_q & i_vs;

endmodule

// File: rtl/vga_stream_ctrl.sv
// Pixel-domain scheduler between the framebuffer pixel FIFO and the VGA
// timing generator. Streaming starts only once the FIFO is primed and a frame
// starts, so a partial frame is never shown. An underflow paints one
// marker pixel, then the FIFO is drained and the stream restarts at the next
// frame boundary. A frame whose pixel count is wrong sets a sticky flag.
module vga_stream_ctrl
    import vga_pkg::*;
#(
    parameter int          HDISP           = HDISP_DEF,
    parameter int          VDISP           = VDISP_DEF,
    parameter int          LEVEL_W         = 10,
    parameter int          FILL_THRESH     = 256,
    parameter logic [23:0] UNDERFLOW_COLOR = 24'hFF00FF
) (
    input  logic               pixel_clk,
    input  logic               pixel_rst,
    input  logic               enable,
    input  logic               vga_hs,
    input  logic               vga_vs,
    input  logic               vga_de,
    input  logic [23:0]        fifo_rdata,
    input  logic               fifo_rempty,
    input  logic [LEVEL_W-1:0] fifo_level,
    output logic               fifo_rd,
    output logic [23:0]        rgb,
    output logic               hs_o,
    output logic               vs_o,
    output logic               de_o,
    output logic               resync_req,
    output logic               underflow,
    output logic               geom_err,
    output logic [7:0]         err_cnt,
    output logic               busy
);

    localparam int FRAME_PIX = HDISP * VDISP;
    localparam int CNT_W     = $clog2(FRAME_PIX + 1);
    localparam int LVL_W1    = LEVEL_W + 1;

    localparam logic [CNT_W-1:0]  FRAME_PIX_C = CNT_W'(FRAME_PIX);
    // One spare bit so a threshold equal to 2**LEVEL_W simply never fires
    localparam logic [LVL_W1-1:0] THRESH_C    = LVL_W1'(FILL_THRESH);

    stream_state_t    r_state;
    rgb_t             r_rgb;
    logic             r_hs;
    logic             r_vs;
    logic             r_de;
    logic             r_resync_req;
    logic             r_underflow;
    logic             r_geom_err;
    logic [7:0]       r_err_cnt;
    logic [CNT_W-1:0] r_pix_cnt;
    // Set when a frame reads past the expected pixel count. The counter
    // itself stops at FRAME_PIX, so this bit keeps long frames visible.
    logic             r_pix_ovf;

    logic w_sync_start;
    logic w_sof;
    logic w_level_ok;
    logic w_fifo_rd;

    vga_frame_evt u_frame_evt (
        .pixel_clk    (pixel_clk),
        .pixel_rst    (pixel_rst),
        .i_vs         (vga_vs),
        .o_sync_start (w_sync_start),
        .o_sof        (w_sof)
    );

    assign w_level_ok = ({1'b0, fifo_level} >= THRESH_C);

    // Read strobe: one per visible pixel while streaming, free-running drain
    // while resynchronising. It is never raised against an empty FIFO.
    always_comb begin
        w_fifo_rd = 1'b0;
        case (r_state)
            STREAM:  w_fifo_rd = vga_de & ~fifo_rempty;
            RESYNC:  w_fifo_rd = ~fifo_rempty;
            default: w_fifo_rd = 1'b0;
        endcase
    end

    // Scheduler FSM with the registered pixel, error flags and frame counter
    always_ff @(posedge pixel_clk or posedge pixel_rst) begin
        if (pixel_rst) begin
            r_state      <= IDLE;
            r_rgb        <= '0;
            r_resync_req <= 1'b0;
            r_underflow  <= 1'b0;
            r_geom_err   <= 1'b0;
            r_err_cnt    <= 8'd0;
            r_pix_cnt    <= '0;
            r_pix_ovf    <= 1'b0;
        end else begin
            r_resync_req <= 1'b0;
            r_rgb        <= '0;
            case (r_state)
                IDLE: begin
                    if (enable) begin
                        r_state <= WAIT_FILL;
                    end
                end
                WAIT_FILL: begin
                    if (!enable) begin
                        r_state <= IDLE;
                    end else if (w_level_ok) begin
                        r_state <= WAIT_SOF;
                    end
                end
                WAIT_SOF: begin
                    if (!enable) begin
                        r_state <= IDLE;
                    end else if (w_sof) begin
                        r_state   <= STREAM;
                        r_pix_cnt <= '0;
                        r_pix_ovf <= 1'b0;
                    end
                end
                STREAM: begin
                    // Sync lies in blanking, so it never meets a DE cycle.
                    // Enable is only looked at here, so a frame always ends.
                    if (w_sync_start) begin
                        if (r_pix_ovf || (r_pix_cnt != FRAME_PIX_C)) begin
                            r_geom_err <= 1'b1;
                        end
                        r_pix_cnt <= '0;
                        r_pix_ovf <= 1'b0;
                        if (!enable) begin
                            r_state <= IDLE;
                        end
                    end else if (vga_de) begin
                        if (fifo_rempty) begin
                            r_rgb       <= rgb_t'(UNDERFLOW_COLOR);
                            r_underflow <= 1'b1;
                            r_err_cnt   <= sat_inc8(r_err_cnt);
                            r_state     <= RESYNC;
                        end else begin
                            r_rgb <= rgb_t'(fifo_rdata);
                            if (r_pix_cnt == FRAME_PIX_C) begin
                                r_pix_ovf <= 1'b1;
                            end else begin
                                r_pix_cnt <= r_pix_cnt + 1'b1;
                            end
                        end
                    end
                end
                RESYNC: begin
                    if (w_sync_start) begin
                        r_resync_req <= 1'b1;
                        r_state      <= enable ? WAIT_FILL : IDLE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    // Sync/DE delayed by one cycle to line up with the registered pixel
    always_ff @(posedge pixel_clk or posedge pixel_rst) begin
        if (pixel_rst) begin
            r_hs <= 1'b1;
            r_vs <= 1'b1;
            r_de <= 1'b0;
        end else begin
            r_hs <= vga_hs;
            r_vs <= vga_vs;
            r_de <= vga_de;
        end
    end

    assign fifo_rd    = w_fifo_rd;
    assign rgb        = r_rgb;
    assign hs_o       = r_hs;
    assign vs_o       = r_vs;
    assign de_o       = r_de;
    assign resync_req = r_resync_req;
    assign underflow  = r_underflow;
    assign geom_err   = r_geom_err;
    assign err_cnt    = r_err_cnt;
    assign busy       = (r_state == STREAM);

endmodule

// File: tb/tb_vga_stream_ctrl.sv
// Directed bench for vga_stream_ctrl on a reduced 4x3 geometry. The bench
// drives a small hand-shaped frame (2 sync, 2 blank, then 3 lines of 4 pixels
// plus 2 blank cycles) and models a show-ahead FIFO with a fill counter.
module tb_vga_stream_ctrl;
    import vga_pkg::*;

    localparam int HD = 4;
    localparam int VD = 3;

    logic        pixel_clk = 1'b0;
    logic        pixel_rst;
    logic        enable;
    logic        vga_hs;
    logic        vga_vs;
    logic        vga_de;
    logic [23:0] fifo_rdata;
    logic        fifo_rempty;
    logic [9:0]  fifo_level;
    logic        fifo_rd;
    logic [23:0] rgb;
    logic        hs_o;
    logic        vs_o;
    logic        de_o;
    logic        resync_req;
    logic        underflow;
    logic        geom_err;
    logic [7:0]  err_cnt;
    logic        busy;

    int          n_vec = 0;
    int          n_fail = 0;
    int          rd_count = 0;
    int          fifo_cnt = 0;
    logic [23:0] head_data = 24'h102030;
    int          fk = 0;
    int          drop_at = -1;
    logic [23:0] rgb_log [0:63];
    logic        rreq_log [0:63];
    logic        uf_log [0:63];

    always #5 pixel_clk = ~pixel_clk;

    vga_stream_ctrl #(
        .HDISP           (HD),
        .VDISP           (VD),
        .LEVEL_W         (10),
        .FILL_THRESH     (256),
        .UNDERFLOW_COLOR (24'hFF00FF)
    ) dut (
        .pixel_clk   (pixel_clk),
        .pixel_rst   (pixel_rst),
        .enable      (enable),
        .vga_hs      (vga_hs),
        .vga_vs      (vga_vs),
        .vga_de      (vga_de),
        .fifo_rdata  (fifo_rdata),
        .fifo_rempty (fifo_rempty),
        .fifo_level  (fifo_level),
        .fifo_rd     (fifo_rd),
        .rgb         (rgb),
        .hs_o        (hs_o),
        .vs_o        (vs_o),
        .de_o        (de_o),
        .resync_req  (resync_req),
        .underflow   (underflow),
        .geom_err    (geom_err),
        .err_cnt     (err_cnt),
        .busy        (busy)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One pixel clock: apply inputs, sample the read strobe, clock, check
    task automatic cyc(input logic hs, input logic vs, input logic de);
        logic        rd_seen;
        logic [23:0] popped;
        vga_hs      = hs;
        vga_vs      = vs;
        vga_de      = de;
        fifo_rdata  = head_data;
        fifo_rempty = (fifo_cnt == 0);
        #1;
        rd_seen = fifo_rd;
        popped  = head_data;
        check("rd_vs_empty", {31'b0, fifo_rd & fifo_rempty}, 32'd0);
        @(posedge pixel_clk);
        #1;
        if (rd_seen) begin
            rd_count++;
            fifo_cnt--;
            head_data = head_data + 24'h010203;
        end
        check("de_o", {31'b0, de_o}, {31'b0, de});
        check("hs_o", {31'b0, hs_o}, {31'b0, hs});
        check("vs_o", {31'b0, vs_o}, {31'b0, vs});
        if (rd_seen && de) begin
            check("rgb_pix", {8'b0, rgb}, {8'b0, popped});
        end else if (!de) begin
            check("rgb_blank", {8'b0, rgb}, 32'd0);
        end
    endtask

    task automatic fstep(input logic hs, input logic vs, input logic de);
        if (fk == drop_at) enable = 1'b0;
        cyc(hs, vs, de);
        rgb_log[fk]  = rgb;
        rreq_log[fk] = resync_req;
        uf_log[fk]   = underflow;
        fk++;
    endtask

    // One frame: 2 VS-low, 2 blank, then lines of HD pixels + 2 blank cycles
    task automatic frame(input int lines, input int drop);
        fk      = 0;
        drop_at = drop;
        for (int i = 0; i < 2; i++) fstep(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 2; i++) fstep(1'b1, 1'b1, 1'b0);
        for (int l = 0; l < lines; l++) begin
            for (int c = 0; c < HD; c++) fstep(1'b1, 1'b1, 1'b1);
            fstep(1'b0, 1'b1, 1'b0);
            fstep(1'b1, 1'b1, 1'b0);
        end
        drop_at = -1;
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) cyc(1'b1, 1'b1, 1'b0);
    endtask

    initial begin
        pixel_rst   = 1'b1;
        enable      = 1'b0;
        vga_hs      = 1'b1;
        vga_vs      = 1'b1;
        vga_de      = 1'b0;
        fifo_rdata  = 24'd0;
        fifo_rempty = 1'b1;
        fifo_level  = 10'd0;
        repeat (2) @(posedge pixel_clk);
        #1;

        // Reset state
        check("rst_rgb", {8'b0, rgb}, 32'd0);
        check("rst_hs", {31'b0, hs_o}, 32'd1);
        check("rst_vs", {31'b0, vs_o}, 32'd1);
        check("rst_de", {31'b0, de_o}, 32'd0);
        check("rst_rreq", {31'b0, resync_req}, 32'd0);
        check("rst_uf", {31'b0, underflow}, 32'd0);
        check("rst_geom", {31'b0, geom_err}, 32'd0);
        check("rst_errcnt", {24'b0, err_cnt}, 32'd0);
        check("rst_busy", {31'b0, busy}, 32'd0);
        check("rst_state", 32'(dut.r_state), 32'(IDLE));
        pixel_rst = 1'b0;

        // Priming: one below threshold holds WAIT_FILL with no reads
        enable     = 1'b1;
        fifo_level = 10'd255;
        fifo_cnt   = 1000;
        cyc(1'b1, 1'b1, 1'b0);
        cyc(1'b1, 1'b1, 1'b1);
        cyc(1'b1, 1'b1, 1'b1);
        check("fill_state", 32'(dut.r_state), 32'(WAIT_FILL));
        check("fill_rd", 32'(rd_count), 32'd0);
        fifo_level = 10'd256;
        cyc(1'b1, 1'b1, 1'b0);
        check("sof_wait_state", 32'(dut.r_state), 32'(WAIT_SOF));
        check("sof_wait_busy", {31'b0, busy}, 32'd0);

        // Two full frames
        frame(VD, -1);
        check("f1_state", 32'(dut.r_state), 32'(STREAM));
        check("f1_busy", {31'b0, busy}, 32'd1);
        check("f1_reads", 32'(rd_count), 32'd12);
        frame(VD, -1);
        check("f2_reads", 32'(rd_count), 32'd24);
        check("f2_geom", {31'b0, geom_err}, 32'd0);

        // One line short: flagged at the next VS falling, streaming continues
        frame(VD - 1, -1);
        check("short_reads", 32'(rd_count), 32'd32);
        check("short_geom_pre", {31'b0, geom_err}, 32'd0);
        frame(VD, -1);
        check("short_geom", {31'b0, geom_err}, 32'd1);
        check("short_busy", {31'b0, busy}, 32'd1);
        check("short_after_reads", 32'(rd_count), 32'd44);

        // Underflow at pixel 5 of the frame (cycle 11 of the frame layout)
        fifo_cnt = 5;
        frame(VD, -1);
        check("uf_pre_flag", {31'b0, uf_log[10]}, 32'd0);
        check("uf_rgb", {8'b0, rgb_log[11]}, 32'hFF00FF);
        check("uf_flag", {31'b0, uf_log[11]}, 32'd1);
        check("uf_resync_rgb", {8'b0, rgb_log[12]}, 32'd0);
        check("uf_errcnt", {24'b0, err_cnt}, 32'd1);
        check("uf_state", 32'(dut.r_state), 32'(RESYNC));
        check("uf_reads", 32'(rd_count), 32'd49);
        fifo_cnt = 3;
        idle_cycles(4);
        check("drain_reads", 32'(rd_count), 32'd52);
        check("drain_rreq", {31'b0, resync_req}, 32'd0);
        fifo_level = 10'd0;
        frame(VD, -1);
        check("rreq_pulse", {31'b0, rreq_log[0]}, 32'd1);
        check("rreq_end", {31'b0, rreq_log[1]}, 32'd0);
        check("resync_state", 32'(dut.r_state), 32'(WAIT_FILL));
        check("resync_reads", 32'(rd_count), 32'd52);
        check("uf_sticky", {31'b0, underflow}, 32'd1);

        // Enable dropped mid-frame: the frame completes, then IDLE
        fifo_cnt   = 1000;
        fifo_level = 10'd256;
        idle_cycles(1);
        frame(VD, -1);
        check("en_stream_reads", 32'(rd_count), 32'd64);
        frame(VD, 10);
        check("drop_reads", 32'(rd_count), 32'd76);
        check("drop_busy", {31'b0, busy}, 32'd1);
        frame(VD, -1);
        check("drop_idle", 32'(dut.r_state), 32'(IDLE));
        check("drop_no_reads", 32'(rd_count), 32'd76);
        check("geom_sticky", {31'b0, geom_err}, 32'd1);

        // Reset mid-line while pixels are streaming
        enable = 1'b1;
        idle_cycles(2);
        frame(VD, -1);
        cyc(1'b1, 1'b0, 1'b0);
        cyc(1'b1, 1'b1, 1'b0);
        cyc(1'b1, 1'b1, 1'b0);
        cyc(1'b1, 1'b1, 1'b1);
        cyc(1'b1, 1'b1, 1'b1);
        check("mid_reads", 32'(rd_count), 32'd90);
        check("mid_de", {31'b0, de_o}, 32'd1);
        pixel_rst = 1'b1;
        #1;
        check("mr_rgb", {8'b0, rgb}, 32'd0);
        check("mr_de", {31'b0, de_o}, 32'd0);
        check("mr_hs", {31'b0, hs_o}, 32'd1);
        check("mr_vs", {31'b0, vs_o}, 32'd1);
        check("mr_busy", {31'b0, busy}, 32'd0);
        check("mr_uf", {31'b0, underflow}, 32'd0);
        check("mr_geom", {31'b0, geom_err}, 32'd0);
        check("mr_errcnt", {24'b0, err_cnt}, 32'd0);
        check("mr_rd", {31'b0, fifo_rd}, 32'd0);
        @(posedge pixel_clk);
        #1;
        pixel_rst = 1'b0;

        // 260 underflow events: counter saturates at 255
        fifo_cnt   = 0;
        fifo_level = 10'd256;
        for (int i = 0; i < 260; i++) begin
            cyc(1'b1, 1'b0, 1'b0);
            cyc(1'b1, 1'b0, 1'b0);
            cyc(1'b1, 1'b1, 1'b0);
            cyc(1'b1, 1'b1, 1'b1);
            if (i == 0) check("sat_first", {24'b0, err_cnt}, 32'd1);
            if (i == 254) check("sat_255", {24'b0, err_cnt}, 32'd255);
        end
        check("sat_hold", {24'b0, err_cnt}, 32'd255);
        check("sat_rgb", {8'b0, rgb}, 32'hFF00FF);
        check("sat_uf", {31'b0, underflow}, 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
